return_stack: RTL and testbench

Parametrised return-address stack (RAS) for the MIPS core's IFU. It predicts `jr $ra` targets by recording `PC+4` on every `jal` and offering the most recent entry as the predicted target. It generalises the fixed single-target `jr` path to a configurable-depth circular stack with wrap-on-overflow, underflow flagging and optional mispredict accounting. It sits beside the PC-select logic and is driven by the decoder's `jal`/`jr` strobes.

---
 rtl/return_stack_pkg.sv | 13 +
 rtl/return_stack_storage.sv | 21 ++
 rtl/return_stack.sv | 131 +++++++++++++
 tb/tb_return_stack.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/return_stack_pkg.sv
// Shared constants and types for the return-address stack.
package return_stack_pkg;
    localparam int RAS_DEPTH = 8;
    localparam int RAS_CNT_W = 16;
    localparam int REG_RA    = 31;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } ras_op_e;
endpackage

// File: rtl/return_stack_storage.sv
// DEPTH x WIDTH entry array: one write port, one combinational read port; not reset.
module ras_storage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/return_stack.sv
// Circular return-address stack with overflow/underflow pulses.
// Optional mispredict pulse and saturating counter under `RAS_MISPREDICT_EN.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = RAS_DEPTH,
    parameter int CNT_W = RAS_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             valid,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             resolve_valid,
    input  logic [WIDTH-1:0] resolve_addr,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]    wp_q, wp_d, waddr, rd_idx;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, we, empty;
    logic [WIDTH-1:0] rdata;
    ras_op_e          op;

    assign empty  = (cnt_q == '0);
    assign rd_idx = wp_q - PW'(1);
    assign valid  = !empty;
    assign full   = (cnt_q == CNT_FULL);
    assign top    = empty ? '0 : rdata;

    ras_storage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_storage (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (push_addr),
        .raddr_i (rd_idx),
        .rdata_o (rdata)
    );

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        op = OP_IDLE;
        if (push && pop && !empty) op = OP_REPL;
        else if (push)             op = OP_PUSH;
        else if (pop)              op = OP_POP;
    end

    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        waddr = wp_q;
        ovf_d = 1'b0;
        unf_d = pop && empty;
        case (op)
            OP_REPL: begin
                we    = 1'b1;
                waddr = rd_idx;
            end
            OP_PUSH: begin
                we   = 1'b1;
                wp_d = wp_q + PW'(1);
                if (full) ovf_d = 1'b1;
                else      cnt_d = cnt_q + (PW+1)'(1);
            end
            OP_POP: begin
                if (!empty) begin
                    wp_d  = rd_idx;
                    cnt_d = cnt_q - (PW+1)'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;

`ifdef RAS_MISPREDICT_EN
    logic             mp_q, mp_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    // An empty stack predicts nothing, so any resolved pop there is a miss.
    always_comb begin
        mp_d   = pop && resolve_valid && (empty || (top != resolve_addr));
        mcnt_d = mcnt_q;
        if (mp_d && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mp_q   <= 1'b0;
            mcnt_q <= '0;
        end else begin
            mp_q   <= mp_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign mispredict     = mp_q;
    assign mispredict_cnt = mcnt_q;
`else
    logic unused_resolve;
    assign unused_resolve = ^{resolve_valid, resolve_addr};
    assign mispredict     = 1'b0;
    assign mispredict_cnt = '0;
`endif
endmodule

// File: tb/tb_return_stack.sv
// Randomised + directed bench for return_stack against a queue-based stack model.
module tb_return_stack;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, push, pop, rv;
    logic [W-1:0]  push_addr, raddr;
    logic [W-1:0]  top;
    logic          valid, full, overflow, underflow, mispredict;
    logic [CW-1:0] mispredict_cnt;

    return_stack #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .push           (push),
        .push_addr      (push_addr),
        .pop            (pop),
        .top            (top),
        .valid          (valid),
        .full           (full),
        .overflow       (overflow),
        .underflow      (underflow),
        .resolve_valid  (rv),
        .resolve_addr   (raddr),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  top;
        logic          valid, full, ovf, unf, mp;
        logic [CW-1:0] mcnt;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] stk[$];
    int           mcnt_m;
    int           vectors = 0;
    int           miscompares = 0;
    event         async_chk;

    function automatic exp_t snap(bit ovf, bit unf, bit mp);
        exp_t e;
        e.top   = (stk.size() != 0) ? stk[stk.size()-1] : '0;
        e.valid = (stk.size() != 0);
        e.full  = (stk.size() == D);
        e.ovf   = ovf;
        e.unf   = unf;
        e.mp    = mp;
        e.mcnt  = CW'(mcnt_m);
        return e;
    endfunction

    task automatic step(bit ps, logic [W-1:0] a, bit pp, bit r, logic [W-1:0] ra);
        bit           empty, ovf, unf, mp;
        logic [W-1:0] pre;
        @(negedge clk);
        push = ps; push_addr = a; pop = pp; rv = r; raddr = ra;
        empty = (stk.size() == 0);
        pre   = empty ? '0 : stk[stk.size()-1];
        ovf = 0; unf = 0; mp = 0;
`ifdef RAS_MISPREDICT_EN
        if (pp && r && (empty || pre != ra)) begin
            mp = 1;
            if (mcnt_m < CMAX) mcnt_m++;
        end
`endif
        if (pp && empty) unf = 1;
        if (ps && pp && !empty) stk[stk.size()-1] = a;
        else if (ps) begin
            if (stk.size() == D) begin
                void'(stk.pop_front());
                ovf = 1;
            end
            stk.push_back(a);
        end else if (pp && !empty) void'(stk.pop_back());
        sb.push_back(snap(ovf, unf, mp));
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0);
    endtask

    // Reset lands mid-cycle while a push is being presented.
    task automatic async_reset();
        @(negedge clk);
        push = 1; push_addr = 32'hDEAD_BEEF; pop = 0; rv = 0;
        #2 reset = 1;
        stk.delete();
        mcnt_m = 0;
        sb.push_back(snap(0, 0, 0));
        -> async_chk;
        @(negedge clk);
        reset = 0; push = 0;
    endtask

    initial begin : monitor
        exp_t e, g;
        forever begin
            @(posedge clk or async_chk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                g = '{top, valid, full, overflow, underflow, mispredict, mispredict_cnt};
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL state @%0t: got top=%h v=%b f=%b ovf=%b unf=%b mp=%b cnt=%0d, want top=%h v=%b f=%b ovf=%b unf=%b mp=%b cnt=%0d",
                             $time, g.top, g.valid, g.full, g.ovf, g.unf, g.mp, g.mcnt,
                             e.top, e.valid, e.full, e.ovf, e.unf, e.mp, e.mcnt);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        reset = 1; push = 0; pop = 0; rv = 0; push_addr = '0; raddr = '0;
        mcnt_m = 0;
        #3;
        sb.push_back(snap(0, 0, 0));
        -> async_chk;
        @(negedge clk);
        reset = 0;

        step(1, 32'h0040_0004, 0, 0, '0);
        step(1, 32'h0040_0010, 0, 0, '0);
        step(1, 32'h0040_0020, 0, 0, '0);
        repeat (3) step(0, '0, 1, 0, '0);
        idle();

        for (int i = 1; i <= 9; i++) step(1, W'(i), 0, 0, '0);
        idle();
        repeat (9) step(0, '0, 1, 0, '0);
        idle();

        step(1, 32'h100, 0, 0, '0);
        step(1, 32'h200, 0, 0, '0);
        step(1, 32'h300, 1, 0, '0);
        step(0, '0, 1, 0, '0);
        step(0, '0, 1, 0, '0);

        step(1, 32'h100, 0, 0, '0);
        step(1, 32'h200, 0, 0, '0);
        step(0, '0, 1, 1, 32'h200);
        step(0, '0, 1, 1, 32'h104);
        step(0, '0, 0, 1, 32'h555);
        repeat (5) step(0, '0, 1, 1, 32'h104);
        step(1, 32'h900, 1, 1, 32'h900);
        idle();

        for (int i = 0; i < 4; i++) step(1, 32'h1000 + W'(i), 0, 0, '0);
        async_reset();
        step(1, 32'hABC, 0, 0, '0);
        idle();

        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] ra;
            if (n % 200 == 150) async_reset();
            ra = $urandom_range(0, 1) ? ((stk.size() != 0) ? stk[stk.size()-1] : '0) : $urandom;
            step($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 1) == 1, ra);
        end
        idle();

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
